ir_tx_scheduler: RTL and testbench
==================================

// Module: ir_tx_scheduler
// PURPOSE
//  Sequencer and arbiter in front of the AC IR transmitter (35-bit + connect + 32-bit frame engine).
//  Holds the AC state (power/mode/temp), turns key pulses into complete frames, and shares the
//  transmitter with a host request port. Enforces one frame in flight plus a minimum inter-frame gap.
// PARAMETERS
//  GAP_CYCLES      12_500_000                   idle clocks after tx_done before next start (100 ms @125 MHz)
//  ACK_TIMEOUT     16                           clocks to wait for tx_busy after tx_start before abort
//  FRAME_HI        23'b10000010000100000000010  constant bits [34:12] of data35
//  DATA32_LO       28'h0400006                  constant bits [27:0] of data32
//  CNT_W           24                           width of gap/timeout counter (must hold GAP_CYCLES)
// PORTS
//  clk          in   1   system clock, 125 MHz
//  rst          in   1   asynchronous, active-low reset
//  key_pwr      in   1   1-cycle pulse, debounced upstream: toggle power
//  key_mode     in   1   1-cycle pulse: next mode
//  key_up       in   1   1-cycle pulse: temp +1
//  key_dn       in   1   1-cycle pulse: temp -1
//  host_valid   in   1   host frame request; held with data until accepted
//  host_ready   out  1   combinational accept; transfer when host_valid && host_ready
//  host_d35     in   35  host frame part 1
//  host_d32     in   32  host frame part 2
//  tx_start     out  1   1-cycle start pulse to transmitter
//  tx_d35       out  35  frame part 1, stable from tx_start until tx_done
//  tx_d32       out  32  frame part 2, same stability
//  tx_busy      in   1   transmitter sending
//  tx_done      in   1   1-cycle pulse, frame complete
//  ac_power     out  1   current power state
//  ac_mode      out  3   current mode 0..4
//  ac_temp      out  4   temp code 0..14 (16..30 C)
//  sched_busy   out  1   state != IDLE
//  tx_abort     out  1   sticky: set on ACK_TIMEOUT, cleared by next successful tx_done
// BEHAVIOUR
//  Reset: ac_power=0, ac_mode=0, ac_temp=9, tx_start=0, tx_d35/d32=0, sched_busy=0, tx_abort=0,
//   loc_pend=0, last_grant=host, FSM=IDLE, counter=0. Reset mid-frame drops tx_start immediately; no resume.
//  Keys (any state): at most one per cycle, priority pwr > mode > up > dn; others that cycle dropped.
//   pwr toggles ac_power; mode wraps 4->0; up saturates 14; dn saturates 0.
//   While ac_power=0 only key_pwr acts; others ignored, no frame. Every state change sets loc_pend
//   (coalescing: several keys during one frame -> one later frame with final state). Saturated no-op sets nothing.
//  Local frame: d35 = {FRAME_HI, ac_temp, 4'b0, ac_power, ac_mode};
//   d32 = {csum, DATA32_LO}, csum = (ac_mode + ac_temp + ac_power + 4'd5) mod 16. Snapshot at grant.
//  FSM:
//   IDLE  : candidates loc_pend, host_valid. Both -> grant side != last_grant (round-robin).
//           Grant: load tx_d35/d32, tx_start=1 next cycle, clear loc_pend (unless a key hits same cycle),
//           host_ready=1 this cycle if host wins, update last_grant -> ACK.
//   ACK   : wait tx_busy=1 -> SEND. Counter >= ACK_TIMEOUT -> tx_abort=1 -> GAP.
//   SEND  : wait tx_done -> GAP (counter cleared).
//   GAP   : count to GAP_CYCLES-1 -> IDLE (or REPEAT, see config). Keys still update state/loc_pend.
//  Latency: grant cycle -> tx_start asserted 1 clock later. host_ready never asserted outside IDLE.
//  tx_done outside SEND ignored. Key arriving in the grant cycle: state updates, loc_pend stays 1.
// CONFIGURATION
//  IR_REPEAT_EN defined: after first GAP, FSM enters REPEAT, re-pulses tx_start with identical frame,
//   ACK -> SEND -> GAP again, then IDLE (two frames per grant; host_ready still single).
//  Undefined: one frame per grant; GAP -> IDLE.
// TESTING
//  Reset, key_pwr pulse -> tx_start 1 clk later, tx_d35[3:0]=4'b1000, tx_d35[11:8]=9, csum=4'hF.
//  Power on, 6x key_up during SEND -> ac_temp=14 (saturate), exactly one further frame after GAP, temp 14.
//  loc_pend and host_valid same cycle, last_grant=host -> local first; host next, host_ready 1 cycle.
//  tx_busy held 0 after tx_start -> tx_abort=1 at ACK_TIMEOUT, GAP honoured, next grant proceeds.
//  rst low during SEND -> all outputs reset values same cycle; after release no tx_start without request.
//  IR_REPEAT_EN: one key -> two tx_start pulses, identical data, spaced >= GAP_CYCLES after tx_done.

Source files
------------

// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: AC state keeper, key-to-frame sequencer and IR transmitter arbiter.
// Define IR_REPEAT_EN to send every granted frame twice, with a full gap between.
module ir_tx_scheduler #(
   parameter int unsigned GAP_CYCLES  = 12_500_000,
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter logic [22:0] FRAME_HI    = 23'b10000010000100000000010,
   parameter logic [27:0] DATA32_LO   = 28'h0400006,
   parameter int unsigned CNT_W       = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_pwr,
   input  logic        key_mode,
   input  logic        key_up,
   input  logic        key_dn,
   input  logic        host_valid,
   output logic        host_ready,
   input  logic [34:0] host_d35,
   input  logic [31:0] host_d32,
   output logic        tx_start,
   output logic [34:0] tx_d35,
   output logic [31:0] tx_d32,
   input  logic        tx_busy,
   input  logic        tx_done,
   output logic        ac_power,
   output logic [2:0]  ac_mode,
   output logic [3:0]  ac_temp,
   output logic        sched_busy,
   output logic        tx_abort
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACK    = 3'd1;
   localparam logic [2:0] S_SEND   = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_REPEAT = 3'd4;

   localparam logic [CNT_W-1:0] L_ACK_TO  = CNT_W'(ACK_TIMEOUT);
   localparam logic [CNT_W-1:0] L_GAP_END = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);

   localparam logic [3:0] TEMP_RST = 4'd9;
   localparam logic [3:0] TEMP_MAX = 4'd14;
   localparam logic [3:0] TEMP_MIN = 4'd0;
   localparam logic [2:0] MODE_MAX = 3'd4;

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_power;
   logic [2:0]       r_mode;
   logic [3:0]       r_temp;
   logic             r_loc_pend;
   logic             r_last_host;
   logic             r_tx_start;
   logic [34:0]      r_tx_d35;
   logic [31:0]      r_tx_d32;
   logic             r_abort;
`ifdef IR_REPEAT_EN
   logic             r_second;
`endif

   logic             w_pwr_nx;
   logic [2:0]       w_mode_nx;
   logic [3:0]       w_temp_nx;
   logic             w_key_chg;
   logic             w_idle;
   logic             w_host_win;
   logic             w_loc_win;
   logic [3:0]       w_csum;
   logic [34:0]      w_loc_d35;
   logic [31:0]      w_loc_d32;

   // One key per cycle by priority; only power acts while the unit is off.
   always_comb begin
      w_pwr_nx  = r_power;
      w_mode_nx = r_mode;
      w_temp_nx = r_temp;
      w_key_chg = 1'b0;
      if (key_pwr) begin
         w_pwr_nx  = ~r_power;
         w_key_chg = 1'b1;
      end else if (r_power) begin
         if (key_mode) begin
            w_mode_nx = (r_mode == MODE_MAX) ? 3'd0 : r_mode + 3'd1;
            w_key_chg = 1'b1;
         end else if (key_up) begin
            if (r_temp != TEMP_MAX) begin
               w_temp_nx = r_temp + 4'd1;
               w_key_chg = 1'b1;
            end
         end else if (key_dn) begin
            if (r_temp != TEMP_MIN) begin
               w_temp_nx = r_temp - 4'd1;
               w_key_chg = 1'b1;
            end
         end
      end
   end

   // Round-robin arbitration between the local frame and the host port.
   always_comb begin
      w_idle     = (r_state == S_IDLE);
      w_host_win = w_idle && host_valid
                   && (!r_loc_pend || !r_last_host);
      w_loc_win  = w_idle && r_loc_pend && !w_host_win;
   end

   // Local frame built from the live AC state; captured only at grant.
   always_comb begin
      w_csum    = {1'b0, r_mode} + r_temp + {3'b000, r_power} + 4'd5;
      w_loc_d35 = {FRAME_HI, r_temp, 4'b0000, r_power, r_mode};
      w_loc_d32 = {w_csum, DATA32_LO};
   end

   // AC state and pending flag; a key in the grant cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_power    <= 1'b0;
         r_mode     <= 3'd0;
         r_temp     <= TEMP_RST;
         r_loc_pend <= 1'b0;
      end else begin
         r_power <= w_pwr_nx;
         r_mode  <= w_mode_nx;
         r_temp  <= w_temp_nx;
         if (w_key_chg) begin
            r_loc_pend <= 1'b1;
         end else if (w_loc_win) begin
            r_loc_pend <= 1'b0;
         end
      end
   end

   // Frame sequencer: grant, wait for ack, wait for done, hold the gap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_last_host <= 1'b1;
         r_tx_start  <= 1'b0;
         r_tx_d35    <= '0;
         r_tx_d32    <= '0;
         r_abort     <= 1'b0;
`ifdef IR_REPEAT_EN
         r_second    <= 1'b0;
`endif
      end else begin
         r_tx_start <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_host_win || w_loc_win) begin
                  r_tx_d35    <= w_host_win ? host_d35 : w_loc_d35;
                  r_tx_d32    <= w_host_win ? host_d32 : w_loc_d32;
                  r_tx_start  <= 1'b1;
                  r_last_host <= w_host_win;
                  r_cnt       <= '0;
                  r_state     <= S_ACK;
`ifdef IR_REPEAT_EN
                  r_second    <= 1'b0;
`endif
               end
            end
            S_ACK: begin
               if (tx_busy) begin
                  r_cnt   <= '0;
                  r_state <= S_SEND;
               end else if (r_cnt >= L_ACK_TO) begin
                  r_abort <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_GAP;
               end else begin
                  r_cnt <= r_cnt + L_ONE;
               end
            end
            S_SEND: begin
               if (tx_done) begin
                  r_abort <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               if (r_cnt >= L_GAP_END) begin
                  r_cnt <= '0;
`ifdef IR_REPEAT_EN
                  r_state <= r_second ? S_IDLE : S_REPEAT;
`else
                  r_state <= S_IDLE;
`endif
               end else begin
                  r_cnt <= r_cnt + L_ONE;
               end
            end
            S_REPEAT: begin
`ifdef IR_REPEAT_EN
               r_tx_start <= 1'b1;
               r_second   <= 1'b1;
               r_cnt      <= '0;
               r_state    <= S_ACK;
`else
               r_state    <= S_IDLE;
`endif
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign host_ready = w_host_win;
   assign tx_start   = r_tx_start;
   assign tx_d35     = r_tx_d35;
   assign tx_d32     = r_tx_d32;
   assign ac_power   = r_power;
   assign ac_mode    = r_mode;
   assign ac_temp    = r_temp;
   assign sched_busy = (r_state != S_IDLE);
   assign tx_abort   = r_abort;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// tb_ir_tx_scheduler: directed stimulus, transmitter responder and a cycle model
// of the scheduler's observable behaviour checked on every clock.
module tb_ir_tx_scheduler;

   localparam int G   = 20;
   localparam int ACK = 16;
   localparam logic [22:0] FHI = 23'b10000010000100000000010;
   localparam logic [27:0] DLO = 28'h0400006;
`ifdef IR_REPEAT_EN
   localparam int REPN = 2;
`else
   localparam int REPN = 1;
`endif
   localparam int INF = 32'h3fffffff;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_pwr, key_mode, key_up, key_dn;
   logic        host_valid;
   logic        host_ready;
   logic [34:0] host_d35;
   logic [31:0] host_d32;
   logic        tx_start;
   logic [34:0] tx_d35;
   logic [31:0] tx_d32;
   logic        tx_busy, tx_done;
   logic        ac_power;
   logic [2:0]  ac_mode;
   logic [3:0]  ac_temp;
   logic        sched_busy;
   logic        tx_abort;

   ir_tx_scheduler #(
      .GAP_CYCLES(G), .ACK_TIMEOUT(ACK), .FRAME_HI(FHI),
      .DATA32_LO(DLO), .CNT_W(24)
   ) dut (
      .clk(clk), .rst(rst),
      .key_pwr(key_pwr), .key_mode(key_mode), .key_up(key_up), .key_dn(key_dn),
      .host_valid(host_valid), .host_ready(host_ready),
      .host_d35(host_d35), .host_d32(host_d32),
      .tx_start(tx_start), .tx_d35(tx_d35), .tx_d32(tx_d32),
      .tx_busy(tx_busy), .tx_done(tx_done),
      .ac_power(ac_power), .ac_mode(ac_mode), .ac_temp(ac_temp),
      .sched_busy(sched_busy), .tx_abort(tx_abort)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n_start = 0;
   int n_hr = 0;
   int ack_en = 1;
   int send_len = 6;
   int stray_req = 0;
   int rsp_cnt = 0;

   function automatic void chk(input string nm, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   function automatic logic sig(input int sel);
      case (sel)
         0: return tx_start;
         1: return tx_busy;
         2: return !sched_busy;
         3: return host_ready;
         default: return tx_abort;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int lim, input string nm);
      bit hit;
      hit = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (sig(sel)) begin
            hit = 1;
            break;
         end
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL %s: no event within %0d cycles", nm, lim);
      end
   endtask

   task automatic press(input int k);
      @(posedge clk); #1;
      key_pwr = (k == 0); key_mode = (k == 1);
      key_up = (k == 2); key_dn = (k == 3);
      @(posedge clk); #1;
      key_pwr = 0; key_mode = 0; key_up = 0; key_dn = 0;
   endtask

   // Transmitter stand-in: acknowledges a start with busy, then a done pulse.
   initial begin
      tx_busy = 0;
      tx_done = 0;
      forever begin
         @(posedge clk); #1;
         tx_done = 0;
         if (!rst) begin
            tx_busy = 0;
            rsp_cnt = 0;
         end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               tx_busy = 0;
               tx_done = 1;
            end
         end else if (tx_start && ack_en != 0) begin
            tx_busy = 1;
            rsp_cnt = send_len;
         end else if (stray_req != 0) begin
            tx_done = 1;
            stray_req = 0;
         end
      end
   end

   int n = 0;
   int m_pwr, m_mode, m_temp;
   int m_pend, m_last_host, m_abort;
   int m_idle_from, m_exp_start;
   int m_inflight, m_sending, m_ack_end;
   int m_rep_left, m_rep_at;
   logic [34:0] m_f35;
   logic [31:0] m_f32;

   task automatic m_reset();
      m_pwr = 0; m_mode = 0; m_temp = 9;
      m_pend = 0; m_last_host = 1; m_abort = 0;
      m_idle_from = 0; m_exp_start = 0;
      m_inflight = 0; m_sending = 0; m_ack_end = INF;
      m_rep_left = 0; m_rep_at = INF;
   endtask

   task automatic m_gap(input int gs);
      m_inflight = 0;
      m_sending = 0;
      m_ack_end = INF;
      if (m_rep_left > 0) begin
         m_rep_left--;
         m_rep_at = gs + G + 1;
      end else begin
         m_idle_from = gs + G;
      end
   endtask

   task automatic m_begin(input int s);
      m_inflight = 1;
      m_sending = 0;
      m_ack_end = s + ACK;
   endtask

   // Model and compare: outputs of this cycle first, then the next-cycle state.
   always @(negedge clk) begin : model
      bit idle, hw, nx;
      int cs;
      n++;
      if (!rst) begin
         m_reset();
         chk("rst tx_start", tx_start, 0);
         chk("rst tx_d35", tx_d35, 0);
         chk("rst tx_d32", tx_d32, 0);
         chk("rst sched_busy", sched_busy, 0);
         chk("rst tx_abort", tx_abort, 0);
         chk("rst ac_temp", ac_temp, 9);
      end else begin
         idle = (n >= m_idle_from);
         chk("sched_busy", sched_busy, !idle);
         hw = idle && host_valid && (m_pend == 0 || m_last_host == 0);
         chk("host_ready", host_ready, hw);
         chk("ac_power", ac_power, m_pwr);
         chk("ac_mode", ac_mode, m_mode);
         chk("ac_temp", ac_temp, m_temp);
         chk("tx_abort", tx_abort, m_abort);
         chk("tx_start", tx_start, m_exp_start);
         if (m_inflight != 0) begin
            chk("tx_d35", tx_d35, m_f35);
            chk("tx_d32", tx_d32, m_f32);
         end
         if (tx_start) n_start++;
         if (host_ready) n_hr++;

         nx = 0;
         if (m_inflight != 0) begin
            if (m_sending != 0) begin
               if (tx_done) begin
                  m_abort = 0;
                  m_gap(n + 1);
               end
            end else if (tx_busy) begin
               m_sending = 1;
            end else if (n == m_ack_end) begin
               m_abort = 1;
               m_gap(n + 1);
            end
         end
         if (n + 1 == m_rep_at) begin
            nx = 1;
            m_rep_at = INF;
            m_begin(n + 1);
         end
         if (idle && (m_pend != 0 || host_valid)) begin
            cs = (m_mode + m_temp + m_pwr + 5) % 16;
            if (hw) begin
               m_f35 = host_d35;
               m_f32 = host_d32;
            end else begin
               m_f35 = {FHI, 4'(m_temp), 4'b0000, 1'(m_pwr), 3'(m_mode)};
               m_f32 = {4'(cs), DLO};
               m_pend = 0;
            end
            m_last_host = hw;
            m_idle_from = INF;
            m_rep_left = REPN - 1;
            nx = 1;
            m_begin(n + 1);
         end
         if (key_pwr) begin
            m_pwr = 1 - m_pwr;
            m_pend = 1;
         end else if (m_pwr != 0) begin
            if (key_mode) begin
               m_mode = (m_mode + 1) % 5;
               m_pend = 1;
            end else if (key_up) begin
               if (m_temp < 14) begin
                  m_temp++;
                  m_pend = 1;
               end
            end else if (key_dn) begin
               if (m_temp > 0) begin
                  m_temp--;
                  m_pend = 1;
               end
            end
         end
         m_exp_start = nx;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: run did not end, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int s0, hr0;
      rst = 0;
      key_pwr = 0; key_mode = 0; key_up = 0; key_dn = 0;
      host_valid = 0; host_d35 = '0; host_d32 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset ac_power", ac_power, 0);
      chk("reset ac_mode", ac_mode, 0);
      chk("reset ac_temp", ac_temp, 9);
      chk("reset sched_busy", sched_busy, 0);
      rst = 1;

      press(0);
      @(negedge clk);
      chk("t1 grant cycle start", tx_start, 0);
      @(negedge clk);
      chk("t1 start", tx_start, 1);
      chk("t1 d35 low", tx_d35[3:0], 4'b1000);
      chk("t1 d35 temp", tx_d35[11:8], 4'd9);
      chk("t1 d35 hi", tx_d35[34:12], FHI);
      chk("t1 csum", tx_d32[31:28], 4'hF);
      chk("t1 d32 lo", tx_d32[27:0], DLO);
      wait_for(2, 300, "t1 idle");

      send_len = 20;
      s0 = n_start;
      press(1);
      wait_for(1, 20, "t2 busy");
      repeat (6) press(2);
      chk("t2 temp saturated", ac_temp, 14);
      chk("t2 still sending", tx_busy, 1);
      for (int r = 1; r < REPN; r++) wait_for(0, 300, "t2 repeat");
      wait_for(0, 300, "t2 refresh");
      chk("t2 temp field", tx_d35[11:8], 4'd14);
      chk("t2 mode field", tx_d35[2:0], 3'd1);
      chk("t2 csum", tx_d32[31:28], 4'h5);
      wait_for(2, 400, "t2 idle");
      send_len = 6;
      repeat (5) @(posedge clk);
      chk("t2 frame count", n_start - s0, 2 * REPN);

      @(posedge clk); #1;
      host_valid = 1;
      host_d35 = 35'h5_1234_5678;
      host_d32 = 32'hCAFE_0001;
      wait_for(3, 50, "t3 host alone ready");
      @(posedge clk); #1;
      host_valid = 0;
      @(negedge clk);
      chk("t3 host alone start", tx_start, 1);
      chk("t3 host alone d35", tx_d35, 35'h5_1234_5678);
      wait_for(1, 20, "t3 host busy");
      @(posedge clk); #1;
      hr0 = n_hr;
      host_valid = 1;
      host_d35 = 35'h2_0F0F_0F0F;
      host_d32 = 32'h1357_9BDF;
      key_dn = 1;
      @(posedge clk); #1;
      key_dn = 0;
      wait_for(0, 300, "t3 local first");
      chk("t3 local first hi", tx_d35[34:12], FHI);
      chk("t3 local first temp", tx_d35[11:8], 4'd13);
      wait_for(3, 400, "t3 host ready");
      @(posedge clk); #1;
      host_valid = 0;
      @(negedge clk);
      chk("t3 host start", tx_start, 1);
      chk("t3 host d35", tx_d35, 35'h2_0F0F_0F0F);
      chk("t3 host d32", tx_d32, 32'h1357_9BDF);
      wait_for(2, 400, "t3 idle");
      chk("t3 ready cycles", n_hr - hr0, 1);

      ack_en = 0;
      press(3);
      wait_for(4, 60, "t4 abort");
      chk("t4 abort set", tx_abort, 1);
      chk("t4 gap held", sched_busy, 1);
      ack_en = 1;
      press(3);
      for (int r = 1; r < REPN; r++) wait_for(0, 300, "t4 repeat");
      wait_for(0, 300, "t4 next grant");
      chk("t4 next temp", tx_d35[11:8], 4'd11);
      wait_for(2, 400, "t4 idle");
      chk("t4 abort cleared", tx_abort, 0);

      stray_req = 1;
      repeat (4) @(posedge clk);
      press(0);
      wait_for(0, 10, "t5 off frame");
      chk("t5 off power bit", tx_d35[3], 0);
      wait_for(2, 400, "t5 idle");
      press(2);
      repeat (5) @(negedge clk);
      chk("t5 off key ignored", ac_temp, 11);
      chk("t5 no frame", sched_busy, 0);
      press(0);
      wait_for(2, 400, "t5 on idle");

      press(1);
      wait_for(1, 20, "t6 busy");
      @(posedge clk); #1;
      rst = 0;
      #1;
      chk("t6 start dropped", tx_start, 0);
      chk("t6 d35 cleared", tx_d35, 0);
      chk("t6 busy cleared", sched_busy, 0);
      chk("t6 power reset", ac_power, 0);
      chk("t6 mode reset", ac_mode, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
      s0 = n_start;
      repeat (40) @(posedge clk);
      chk("t6 no resume", n_start - s0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
